// File: rtl/haar_pair_gen_pkg.sv
// Shared definitions for the Haar pair generator: default pixel width,
// the even/odd phase encoding and the index-width helper.
package haar_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  // Never returns 0 so that a single-pair row still gets a 1-bit index.
  function automatic int idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/haar_pair_gen_if.sv
// Pixel-in / pair-out bundle for haar_pair_gen.
// avg_out exists only when HAAR_AVG_EN is defined.
interface haar_pair_gen_if #(
  parameter int PIX_W = haar_pkg::PIX_W_DEF,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
);
  import haar_pkg::*;

  localparam int COL_W = idx_w(IMG_W / 2);
  localparam int ROW_W = idx_w(IMG_H);

  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] p1;
  logic [PIX_W-1:0] p2;
  logic             pair_valid;
  logic             pair_ready;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;
  logic             sof;
  logic             eol;
  logic             eof;
`ifdef HAAR_AVG_EN
  logic [PIX_W-1:0] avg_out;

  modport master (
    output pix_in, pix_valid, pair_ready,
    input  pix_ready, p1, p2, pair_valid, col_idx, row_idx, sof, eol, eof, avg_out
  );

  modport slave (
    input  pix_in, pix_valid, pair_ready,
    output pix_ready, p1, p2, pair_valid, col_idx, row_idx, sof, eol, eof, avg_out
  );
`else
  modport master (
    output pix_in, pix_valid, pair_ready,
    input  pix_ready, p1, p2, pair_valid, col_idx, row_idx, sof, eol, eof
  );

  modport slave (
    input  pix_in, pix_valid, pair_ready,
    output pix_ready, p1, p2, pair_valid, col_idx, row_idx, sof, eol, eof
  );
`endif

endinterface

// File: rtl/haar_pair_gen.sv
// Pairs horizontally adjacent raster pixels into registered (p1,p2) operands
// with position/frame flags and a one-pair output buffer. HAAR_AVG_EN adds avg_out.
module haar_pair_gen
  import haar_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  haar_pair_gen_if.slave bus
);

  localparam int COL_W = idx_w(IMG_W / 2);
  localparam int ROW_W = idx_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W / 2 - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  phase_t           phase_reg;
  phase_t           phase_next;
  logic [PIX_W-1:0] even_reg;
  logic [PIX_W-1:0] p1_reg;
  logic [PIX_W-1:0] p2_reg;
  logic             pair_valid_reg;
  logic [COL_W-1:0] col_idx_reg;
  logic [ROW_W-1:0] row_idx_reg;
  logic             sof_reg;
  logic             eol_reg;
  logic             eof_reg;
  // Position of the next pair to be loaded; col_idx/row_idx hold the current pair's.
  logic [COL_W-1:0] col_cnt_reg;
  logic [ROW_W-1:0] row_cnt_reg;

  logic pix_ready;
  logic accept;
  logic store_even;
  logic load_pair;
  logic consume;
  logic col_wrap;
  logic row_wrap;

  // Phase FSM: next state and handshake decode
  always_comb begin
    phase_next = phase_reg;
    pix_ready  = 1'b1;
    store_even = 1'b0;
    load_pair  = 1'b0;
    accept     = 1'b0;
    case (phase_reg)
      EVEN: begin
        pix_ready  = 1'b1;
        accept     = bus.pix_valid;
        store_even = accept;
        if (accept) begin
          phase_next = ODD;
        end
      end
      ODD: begin
        pix_ready = !pair_valid_reg || bus.pair_ready;
        accept    = bus.pix_valid && pix_ready;
        load_pair = accept;
        if (accept) begin
          phase_next = EVEN;
        end
      end
      default: begin
        phase_next = EVEN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= EVEN;
    end else begin
      phase_reg <= phase_next;
    end
  end

  assign consume  = pair_valid_reg && bus.pair_ready;
  assign col_wrap = (col_cnt_reg == COL_LAST);
  assign row_wrap = (row_cnt_reg == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      even_reg <= '0;
    end else if (store_even) begin
      even_reg <= bus.pix_in;
    end
  end

  // Output register: a load in the same cycle as a consume wins, keeping pair_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_reg         <= '0;
      p2_reg         <= '0;
      pair_valid_reg <= 1'b0;
      col_idx_reg    <= '0;
      row_idx_reg    <= '0;
      sof_reg        <= 1'b0;
      eol_reg        <= 1'b0;
      eof_reg        <= 1'b0;
    end else if (load_pair) begin
      p1_reg         <= even_reg;
      p2_reg         <= bus.pix_in;
      pair_valid_reg <= 1'b1;
      col_idx_reg    <= col_cnt_reg;
      row_idx_reg    <= row_cnt_reg;
      sof_reg        <= (col_cnt_reg == '0) && (row_cnt_reg == '0);
      eol_reg        <= col_wrap;
      eof_reg        <= col_wrap && row_wrap;
    end else if (consume) begin
      pair_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
    end else if (load_pair) begin
      if (col_wrap) begin
        col_cnt_reg <= '0;
        row_cnt_reg <= row_wrap ? '0 : row_cnt_reg + 1'b1;
      end else begin
        col_cnt_reg <= col_cnt_reg + 1'b1;
      end
    end
  end

`ifdef HAAR_AVG_EN
  // One extra sum bit so 255+255 averages to 255 rather than wrapping.
  logic [PIX_W:0]   sum;
  logic [PIX_W-1:0] avg_reg;

  assign sum = {1'b0, even_reg} + {1'b0, bus.pix_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_reg <= '0;
    end else if (load_pair) begin
      avg_reg <= sum[PIX_W:1];
    end
  end

  assign bus.avg_out = avg_reg;
`endif

  assign bus.pix_ready  = pix_ready;
  assign bus.p1         = p1_reg;
  assign bus.p2         = p2_reg;
  assign bus.pair_valid = pair_valid_reg;
  assign bus.col_idx    = col_idx_reg;
  assign bus.row_idx    = row_idx_reg;
  assign bus.sof        = sof_reg;
  assign bus.eol        = eol_reg;
  assign bus.eof        = eof_reg;

endmodule

// File: tb/tb_haar_pair_gen.sv
// Self-checking bench for haar_pair_gen (IMG_W=8, IMG_H=2): directed streams,
// stalls, gaps, mid-frame reset and random traffic against a pair-queue model.
module tb_haar_pair_gen;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 2;
  localparam int PIX_W  = 8;
  localparam int PAIRS_ROW = IMG_W / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  haar_pair_gen_if #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

  haar_pair_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int col;
    int row;
    bit sof;
    bit eol;
    bit eof;
  } pair_t;

  int    checks = 0;
  int    errors = 0;
  pair_t exp_q[$];
  bit    have_even = 1'b0;
  int    even_pix = 0;
  int    pair_cnt = 0;
  bit    last_acc = 1'b0;
  int    pix[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pair k of a frame stream sits at column k mod (W/2) of row (k div (W/2)) mod H.
  function automatic pair_t make_pair(input int a, input int b, input int k);
    pair_t p;
    p.a   = a;
    p.b   = b;
    p.col = k % PAIRS_ROW;
    p.row = (k / PAIRS_ROW) % IMG_H;
    p.sof = (k % (PAIRS_ROW * IMG_H)) == 0;
    p.eol = p.col == PAIRS_ROW - 1;
    p.eof = p.eol && (p.row == IMG_H - 1);
    return p;
  endfunction

  // One clock: drive, compare against the model, advance the model on the edge.
  task automatic cycle(input bit v, input int d, input bit pr);
    bit    exp_ready;
    bit    acc;
    bit    cons;
    pair_t e;
    bus.pix_valid  = v;
    bus.pix_in     = d[PIX_W-1:0];
    bus.pair_ready = pr;
    #1;
    check("pair_valid", {31'd0, bus.pair_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("p1", bus.p1, e.a);
      check("p2", bus.p2, e.b);
      check("col_idx", bus.col_idx, e.col);
      check("row_idx", bus.row_idx, e.row);
      check("sof", bus.sof, e.sof);
      check("eol", bus.eol, e.eol);
      check("eof", bus.eof, e.eof);
`ifdef HAAR_AVG_EN
      check("avg_out", bus.avg_out, (e.a + e.b) / 2);
`endif
    end
    exp_ready = !have_even || (exp_q.size() == 0) || pr;
    check("pix_ready", bus.pix_ready, exp_ready);
    acc  = v && exp_ready;
    cons = pr && (exp_q.size() != 0);
    last_acc = acc;
    @(posedge clk);
    if (cons) begin
      void'(exp_q.pop_front());
    end
    if (acc) begin
      if (!have_even) begin
        even_pix  = d;
        have_even = 1'b1;
      end else begin
        exp_q.push_back(make_pair(even_pix, d, pair_cnt));
        pair_cnt++;
        have_even = 1'b0;
      end
    end
    #1;
  endtask

  // mode 0: continuous, 1: 5-cycle downstream stall, 2: 3-cycle input gaps, 3: random
  task automatic run(input int mode);
    int idx = 0;
    int cyc = 0;
    bit v;
    bit pr;
    while (idx < pix.size() || exp_q.size() != 0) begin
      case (mode)
        1:       begin v = 1'b1; pr = !(cyc >= 2 && cyc < 7); end
        2:       begin v = (cyc % 4) == 0; pr = 1'b1; end
        3:       begin v = $urandom_range(0, 9) < 6; pr = $urandom_range(0, 9) < 7; end
        default: begin v = 1'b1; pr = 1'b1; end
      endcase
      if (idx >= pix.size()) begin
        v  = 1'b0;
        pr = (mode == 3) ? pr : 1'b1;
      end
      cycle(v, (idx < pix.size()) ? pix[idx] : 0, pr);
      if (last_acc) begin
        idx++;
      end
      cyc++;
      if (cyc > 4000) begin
        check("run_timeout", cyc, 0);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_pair_valid", {31'd0, bus.pair_valid}, 0);
    check("rst_p1", bus.p1, 0);
    check("rst_p2", bus.p2, 0);
    check("rst_col_idx", bus.col_idx, 0);
    check("rst_row_idx", bus.row_idx, 0);
    check("rst_flags", {29'd0, bus.sof, bus.eol, bus.eof}, 0);
    check("rst_pix_ready", {31'd0, bus.pix_ready}, 1);
`ifdef HAAR_AVG_EN
    check("rst_avg_out", bus.avg_out, 0);
`endif
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    have_even = 1'b0;
    pair_cnt  = 0;
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  task automatic load_ramp(input int n, input int start, input int step);
    pix.delete();
    for (int i = 0; i < n; i++) begin
      pix.push_back((start + i * step) % 256);
    end
  endtask

  initial begin
    bus.pix_valid  = 1'b0;
    bus.pix_in     = '0;
    bus.pair_ready = 1'b0;
    #3;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Frame 1: 10..160 back to back, pairs every 2 cycles
    load_ramp(16, 10, 10);
    run(0);
    $display("stream continuous: pairs=%0d", pair_cnt);

    // Frame 2: same data with a 5-cycle downstream stall after the first pair
    load_ramp(16, 10, 10);
    run(1);
    $display("stream stalled: pairs=%0d", pair_cnt);

    // Frame 3: 3-cycle gaps between pixels
    load_ramp(16, 10, 10);
    run(2);
    $display("stream gapped: pairs=%0d", pair_cnt);

    // Mid-frame reset after 3 accepted pixels, then pair (5,6) from a clean start
    load_ramp(3, 1, 1);
    run(0);
    pulse_reset();
    pix.delete();
    pix.push_back(5);
    pix.push_back(6);
    run(0);
    $display("reset recovery: pairs=%0d", pair_cnt);

    // Averager corner values (also plain pair checks without the averager)
    pix.delete();
    pix.push_back(255); pix.push_back(255);
    pix.push_back(0);   pix.push_back(1);
    pix.push_back(100); pix.push_back(50);
    run(0);
    $display("avg corners: pairs=%0d", pair_cnt);

    // Random traffic across several frames
    for (int r = 0; r < 6; r++) begin
      pix.delete();
      for (int i = 0; i < 40; i++) begin
        pix.push_back($urandom_range(0, 255));
      end
      run(3);
      $display("random burst %0d: pairs=%0d", r, pair_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
